// File: rtl/xillybus_user_fifo.sv
// Single-clock user FIFO between a Xillybus write stream and read stream.
// Define XILLYBUS_USER_FIFO_EOF_EN to drive user_r_eof_w from the writer session.
module xillybus_user_fifo #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 9,
    parameter int AFULL_LVL = (1 << ADDR_W) - 16
) (
    input  logic              bus_clk_w,
    input  logic              trn_reset_n_w,
    input  logic              user_w_wren_w,
    input  logic [DATA_W-1:0] user_w_data_w,
    input  logic              user_w_open_w,
    output logic              user_w_full_w,
    input  logic              user_r_rden_w,
    input  logic              user_r_open_w,
    output logic [DATA_W-1:0] user_r_data_w,
    output logic              user_r_empty_w,
    output logic              user_r_eof_w,
    output logic [ADDR_W:0]   fill_count_w,
    output logic              almost_full_w,
    output logic              overflow_w,
    output logic              underflow_w
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AFULL_C = (ADDR_W+1)'(AFULL_LVL);

    typedef enum logic [1:0] {
        IDLE,
        WOPEN,
        WCLOSED
    } wstate_e;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   count_d;
    logic              ovf_q;
    logic              unf_q;
    logic [DATA_W-1:0] rdata_q;
    wstate_e           state_q;
    wstate_e           state_d;

    logic flush;
    logic wr_ok;
    logic rd_ok;

    // Both streams closed means the session is over: drop everything.
    assign flush = !user_w_open_w && !user_r_open_w;
    assign wr_ok = user_w_wren_w && !user_w_full_w && !flush;
    assign rd_ok = user_r_rden_w && !user_r_empty_w && !flush;

    assign user_w_full_w  = (count_q == FULL_C);
    assign user_r_empty_w = (count_q == '0);
    assign almost_full_w  = (count_q >= AFULL_C);
    assign fill_count_w   = count_q;
    assign overflow_w     = ovf_q;
    assign underflow_w    = unf_q;
    assign user_r_data_w  = rdata_q;

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            unique case ({wr_ok, rd_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (user_w_open_w)  state_d = WOPEN;
                WOPEN:   if (!user_w_open_w) state_d = WCLOSED;
                WCLOSED: if (user_w_open_w)  state_d = WOPEN;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge bus_clk_w or negedge trn_reset_n_w) begin
        if (!trn_reset_n_w) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge bus_clk_w or negedge trn_reset_n_w) begin
        if (!trn_reset_n_w) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            if (user_w_wren_w && user_w_full_w) ovf_q <= 1'b1;
            if (user_r_rden_w && user_r_empty_w) unf_q <= 1'b1;
        end
    end

    always_ff @(posedge bus_clk_w or negedge trn_reset_n_w) begin
        if (!trn_reset_n_w) begin
            rdata_q <= '0;
        end else if (rd_ok) begin
            rdata_q <= mem[rd_ptr];
        end
    end

    // Storage is not reset; stale words are unreachable once pointers clear.
    always_ff @(posedge bus_clk_w) begin
        if (wr_ok) mem[wr_ptr] <= user_w_data_w;
    end

`ifdef XILLYBUS_USER_FIFO_EOF_EN
    logic eof_q;

    // Built from next-state so it rises in the same cycle as empty.
    always_ff @(posedge bus_clk_w or negedge trn_reset_n_w) begin
        if (!trn_reset_n_w) begin
            eof_q <= 1'b0;
        end else begin
            eof_q <= (state_d == WCLOSED) && (count_d == '0);
        end
    end

    assign user_r_eof_w = eof_q;
`else
    assign user_r_eof_w = 1'b0;
`endif

endmodule

// File: tb/tb_xillybus_user_fifo.sv
// Directed plus randomized bench for xillybus_user_fifo against a queue model.
module tb_xillybus_user_fifo;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int DEPTH = 16;

    localparam int S_IDLE   = 0;
    localparam int S_OPEN   = 1;
    localparam int S_CLOSED = 2;

    logic          clk;
    logic          rst_n;
    logic          wren;
    logic [DW-1:0] wdata;
    logic          wopen;
    logic          full;
    logic          rden;
    logic          ropen;
    logic [DW-1:0] rdata;
    logic          empty;
    logic          eof;
    logic [AW:0]   fill;
    logic          afull;
    logic          ovf;
    logic          unf;

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_data;
    logic          m_ovf;
    logic          m_unf;
    int            m_sess;

    xillybus_user_fifo #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .AFULL_LVL(12)
    ) dut (
        .bus_clk_w     (clk),
        .trn_reset_n_w (rst_n),
        .user_w_wren_w (wren),
        .user_w_data_w (wdata),
        .user_w_open_w (wopen),
        .user_w_full_w (full),
        .user_r_rden_w (rden),
        .user_r_open_w (ropen),
        .user_r_data_w (rdata),
        .user_r_empty_w(empty),
        .user_r_eof_w  (eof),
        .fill_count_w  (fill),
        .almost_full_w (afull),
        .overflow_w    (ovf),
        .underflow_w   (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        logic e_eof;
        n = mq.size();
`ifdef XILLYBUS_USER_FIFO_EOF_EN
        e_eof = (m_sess == S_CLOSED) && (n == 0);
`else
        e_eof = 1'b0;
`endif
        chk({tag, ".count"}, 64'(fill), 64'(n));
        chk({tag, ".full"},  64'(full), 64'(n == DEPTH));
        chk({tag, ".empty"}, 64'(empty), 64'(n == 0));
        chk({tag, ".afull"}, 64'(afull), 64'(n >= 12));
        chk({tag, ".ovf"},   64'(ovf), 64'(m_ovf));
        chk({tag, ".unf"},   64'(unf), 64'(m_unf));
        chk({tag, ".eof"},   64'(eof), 64'(e_eof));
        chk({tag, ".data"},  64'(rdata), 64'(m_data));
    endtask

    task automatic model_reset();
        mq.delete();
        m_data = '0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_sess = S_IDLE;
    endtask

    // One clock of the FIFO's rules applied to the queue model.
    task automatic model_step(input logic we, input logic [DW-1:0] wd,
                              input logic re, input logic wo,
                              input logic ro);
        bit was_full;
        bit was_empty;
        if (!wo && !ro) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
            m_sess = S_IDLE;
            return;
        end
        was_full  = (mq.size() == DEPTH);
        was_empty = (mq.size() == 0);
        if (re && !was_empty) m_data = mq.pop_front();
        if (we && !was_full) mq.push_back(wd);
        if (we && was_full) m_ovf = 1'b1;
        if (re && was_empty) m_unf = 1'b1;
        if (wo) m_sess = S_OPEN;
        else if (m_sess == S_OPEN) m_sess = S_CLOSED;
    endtask

    task automatic cycle(input string tag,
                         input logic we, input logic [DW-1:0] wd,
                         input logic re, input logic wo,
                         input logic ro);
        wren  = we;
        wdata = wd;
        rden  = re;
        wopen = wo;
        ropen = ro;
        @(posedge clk);
        model_step(we, wd, re, wo, ro);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        wren  = 1'b0;
        wdata = '0;
        rden  = 1'b0;
        wopen = 1'b0;
        ropen = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Fill to full, then one refused write.
        for (int i = 1; i <= 16; i++)
            cycle("fill", 1'b1, DW'(i), 1'b0, 1'b1, 1'b1);
        cycle("ovf", 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1);

        // Read and write together while full.
        cycle("full_rw", 1'b1, 32'h1234_5678, 1'b1, 1'b1, 1'b1);
        chk("full_rw.first", 64'(rdata), 64'h1);
        for (int i = 0; i < 16; i++)
            cycle("drain", 1'b0, '0, 1'b1, 1'b1, 1'b1);

        cycle("flush0", 1'b0, '0, 1'b0, 1'b0, 1'b0);

        // Read and write together while empty.
        cycle("empty_rw", 1'b1, 32'hA5A5_A5A5, 1'b1, 1'b1, 1'b1);
        cycle("empty_rd", 1'b0, '0, 1'b1, 1'b1, 1'b1);
        chk("empty_rd.val", 64'(rdata), 64'hA5A5_A5A5);

        // Streaming through two pointer wraps.
        for (int i = 0; i < 40; i++)
            cycle("stream", 1'b1, 32'h100 + DW'(i), 1'b1, 1'b1, 1'b1);
        cycle("stream_end", 1'b0, '0, 1'b1, 1'b1, 1'b1);

        // Writer session close and end-of-file.
        cycle("flush1", 1'b0, '0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            cycle("eof_wr", 1'b1, 32'h700 + DW'(i), 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++)
            cycle("eof_rd", 1'b0, '0, 1'b1, 1'b0, 1'b1);
        cycle("eof_hold", 1'b0, '0, 1'b0, 1'b0, 1'b1);
        cycle("reopen", 1'b0, '0, 1'b0, 1'b1, 1'b1);

        // Flush with words stored.
        for (int i = 0; i < 5; i++)
            cycle("five", 1'b1, $urandom, 1'b0, 1'b1, 1'b1);
        cycle("flush5", 1'b1, $urandom, 1'b1, 1'b0, 1'b0);

        // Random traffic, opens mostly held.
        for (int i = 0; i < 600; i++)
            cycle("rand",
                  1'($urandom_range(0, 2) != 0), $urandom,
                  1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 15) != 0),
                  1'($urandom_range(0, 15) != 0));

        // Reset between edges in the middle of a burst.
        for (int i = 0; i < 6; i++)
            cycle("burst", 1'b1, $urandom, 1'b0, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        cycle("post_rst", 1'b0, '0, 1'b1, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
